// File: rtl/adc_idelay_scan_ctrl.sv
// adc_idelay_scan_ctrl: sweeps the shared IDELAY tap, finds the widest passing window and loads its centre
module adc_idelay_scan_ctrl #(
    parameter int unsigned TAP_MAX    = 511,
    parameter int unsigned TAP_STEP   = 8,
    parameter int unsigned SETTLE_CYC = 16,
    parameter int unsigned CHECK_CYC  = 256
) (
    input  logic        clk_div,
    input  logic        rst,
    input  logic        start,
    input  logic [9:0]  pattern,
    input  logic [79:0] data,
    output logic        load,
    output logic [8:0]  cntvalue,
    output logic        busy,
    output logic        done,
    output logic        fail,
    output logic [8:0]  best_tap,
    output logic [9:0]  win_len
);
    localparam int unsigned CMAX = SETTLE_CYC > CHECK_CYC ? SETTLE_CYC : CHECK_CYC;
    localparam int CW = $clog2(CMAX + 1);
    typedef enum logic [2:0] {IDLE, LOAD, SETTLE, CHECK, EVAL, CENTER, DONE} state_t;
    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [8:0]    tap_q, cur_start_q, best_start_q, best_end_q;
    logic [9:0]    cur_len_q, best_len_q;
    logic          err_q;
    logic          mism, better, last_pt, cnt_end;
    logic [9:0]    cur_len_d, best_len_d, next_tap;
    logic [8:0]    cur_start_d, best_start_d, best_end_d, centre;
    // sample compare plus the window bookkeeping applied when a sweep point closes
    always_comb begin
        mism = 1'b0;
        for (int k = 0; k < 8; k++) mism = mism | (data[10*k +: 10] != pattern);
        cur_len_d    = err_q ? 10'd0 : cur_len_q + 10'd1;
        cur_start_d  = cur_len_q == 10'd0 ? tap_q : cur_start_q;
        better       = !err_q && cur_len_d > best_len_q;
        best_len_d   = better ? cur_len_d : best_len_q;
        best_start_d = better ? cur_start_d : best_start_q;
        best_end_d   = better ? tap_q : best_end_q;
        next_tap     = {1'b0, tap_q} + 10'(TAP_STEP);
        last_pt      = next_tap > 10'(TAP_MAX);
        centre       = 9'(({1'b0, best_start_d} + {1'b0, best_end_d}) >> 1);
        cnt_end      = cnt_q == CW'((state_q == SETTLE ? SETTLE_CYC : CHECK_CYC) - 1);
    end
    // scan sequencer with registered strobes and held results
    always_ff @(posedge clk_div) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            tap_q        <= '0;
            cur_start_q  <= '0;
            best_start_q <= '0;
            best_end_q   <= '0;
            cur_len_q    <= '0;
            best_len_q   <= '0;
            err_q        <= 1'b0;
            load         <= 1'b0;
            cntvalue     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            fail         <= 1'b0;
            best_tap     <= '0;
            win_len      <= '0;
        end else begin
            load <= 1'b0;
            done <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    tap_q      <= '0;
                    cur_len_q  <= '0;
                    best_len_q <= '0;
                    err_q      <= 1'b0;
                    busy       <= 1'b1;
                    load       <= 1'b1;
                    cntvalue   <= '0;
                    state_q    <= LOAD;
                end
                LOAD: begin
                    cnt_q   <= '0;
                    state_q <= SETTLE;
                end
                SETTLE: begin
                    err_q   <= 1'b0;
                    cnt_q   <= cnt_end ? '0 : cnt_q + 1'b1;
                    state_q <= cnt_end ? CHECK : SETTLE;
                end
                CHECK: begin
                    err_q   <= err_q | mism;
                    cnt_q   <= cnt_end ? '0 : cnt_q + 1'b1;
                    state_q <= cnt_end ? EVAL : CHECK;
                end
                EVAL: begin
                    cur_len_q    <= cur_len_d;
                    cur_start_q  <= cur_start_d;
                    best_len_q   <= best_len_d;
                    best_start_q <= best_start_d;
                    best_end_q   <= best_end_d;
                    load         <= 1'b1;
                    if (last_pt) begin
                        state_q  <= CENTER;
                        cntvalue <= best_len_d == 10'd0 ? 9'd0 : centre;
                        best_tap <= best_len_d == 10'd0 ? 9'd0 : centre;
                        win_len  <= best_len_d;
                        fail     <= best_len_d == 10'd0;
                    end else begin
                        tap_q    <= next_tap[8:0];
                        cntvalue <= next_tap[8:0];
                        state_q  <= LOAD;
                    end
                end
                CENTER: begin
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    state_q <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adc_idelay_scan_ctrl.sv
// tb_adc_idelay_scan_ctrl: receiver-side stimulus with a schedule/window reference model checked every cycle
module tb_adc_idelay_scan_ctrl;
    localparam int S = 4, C = 16, TM = 511, TS = 8, N = TM / TS + 1, P = S + C + 2;
    logic        clk_div = 1'b0;
    logic        rst = 1'b1, start = 1'b0;
    logic [9:0]  pattern = 10'h2a5;
    logic [79:0] data = '0;
    logic        load, busy, done, fail;
    logic [8:0]  cntvalue, best_tap;
    logic [9:0]  win_len;
    int          checks = 0, failures = 0, n_load = 0, n_done = 0, shown = 0;
    logic [63:0] pmask = '0;
    int          g_tap = -1, g_smp = 0, g_bit = 0;

    adc_idelay_scan_ctrl #(.TAP_MAX(TM), .TAP_STEP(TS), .SETTLE_CYC(S), .CHECK_CYC(C)) dut (
        .clk_div(clk_div), .rst(rst), .start(start), .pattern(pattern), .data(data),
        .load(load), .cntvalue(cntvalue), .busy(busy), .done(done), .fail(fail),
        .best_tap(best_tap), .win_len(win_len)
    );

    always #5 clk_div = ~clk_div;

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    function automatic logic [63:0] win(input int a, input int b);
        logic [63:0] m = '0;
        for (int i = a; i <= b; i++) m[i] = 1'b1;
        return m;
    endfunction

    // reference model: scan timing from the start cycle, outcome from per-point pass flags
    bit          act = 0, armed = 0, e_load, e_busy, e_done, e_fail = 0;
    int          rel = 0;
    bit          errp [N];
    logic [8:0]  e_cnt = '0, e_best = '0;
    logic [9:0]  e_win = '0;
    logic [31:0] got_v, exp_v;

    function automatic void score();
        int best = 0, bs = 0, b;
        for (int a = 0; a < N; a++)
            if (!errp[a] && (a == 0 || errp[a-1])) begin
                b = a;
                while (b + 1 < N && !errp[b+1]) b++;
                if (b - a + 1 > best) begin
                    best = b - a + 1;
                    bs = a;
                end
            end
        e_win  = 10'(best);
        e_fail = best == 0;
        e_best = best == 0 ? 9'd0 : 9'((bs * TS + (bs + best - 1) * TS) / 2);
    endfunction

    initial forever begin
        @(negedge clk_div);
        if (armed) begin
            e_load = act && ((rel < N*P && rel % P == 0) || rel == N*P);
            e_busy = act && rel <= N*P;
            e_done = act && rel == N*P + 1;
            if (e_load) e_cnt = rel < N*P ? 9'(rel / P * TS) : e_best;
            exp_v = {e_load, e_cnt, e_busy, e_done, e_fail, e_best, e_win};
            got_v = {load, cntvalue, busy, done, fail, best_tap, win_len};
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                if (shown < 20) $display("FAIL cycle_outputs rel=%0d got=%h expected=%h", rel, got_v, exp_v);
                shown++;
            end
        end
        n_load += int'(load === 1'b1);
        n_done += int'(done === 1'b1);
        if (rst) begin
            armed = 1;
            act = 0;
            e_cnt = '0;
            e_best = '0;
            e_fail = 0;
            e_win = '0;
        end else begin
            if (act && rel < N*P && rel % P > S && rel % P <= S + C && data != {8{pattern}}) errp[rel / P] = 1;
            if (act && rel == N*P - 1) score();
            if (!act && start) begin
                act = 1;
                rel = 0;
                foreach (errp[i]) errp[i] = 0;
            end else if (act) begin
                rel++;
                if (rel > N*P + 1) act = 0;
            end
        end
    end

    // receiver: follows the loaded tap and presents clean or corrupted words
    int          since = 1000, bad_at = 0, g_at = 0;
    logic [8:0]  rx_tap = '0;
    logic [79:0] w;
    initial forever begin
        @(posedge clk_div);
        #1;
        if (load === 1'b1) begin
            rx_tap = cntvalue;
            since = 0;
            bad_at = $urandom_range(S + 1, S + C);
            g_at = $urandom_range(S + 1, S + C);
        end else since++;
        w = {8{pattern}};
        if (since > S && since <= S + C) begin
            if (since == bad_at && !(rx_tap[2:0] == 3'd0 && pmask[rx_tap[8:3]])) w[$urandom_range(0, 79)] ^= 1'b1;
            if (int'(rx_tap) == g_tap && since == g_at) w[g_smp * 10 + g_bit] ^= 1'b1;
        end else if ($urandom_range(0, 1) == 1) w = w ^ {$urandom, $urandom, 16'($urandom)};
        data = w;
    end

    task automatic run_scan(input string nm, input logic [63:0] m, input bit noisy);
        bit got = 0;
        int l0, d0;
        pmask = m;
        l0 = n_load;
        d0 = n_done;
        @(posedge clk_div);
        #1 start = 1'b1;
        @(posedge clk_div);
        #1 start = 1'b0;
        for (int i = 0; i < N*P + 50 && !got; i++) begin
            if (done === 1'b1) got = 1;
            else begin
                start = noisy && busy === 1'b1 && $urandom_range(0, 15) == 0;
                @(posedge clk_div);
                #1 start = 1'b0;
            end
        end
        chk({nm, "_done_seen"}, int'(got), 1);
        @(negedge clk_div);
        #1;
        chk({nm, "_loads"}, n_load - l0, N + 1);
        chk({nm, "_dones"}, n_done - d0, 1);
    endtask

    task automatic res(input string nm, input int bt, input int wl, input int f);
        chk({nm, "_best_tap"}, best_tap, bt);
        chk({nm, "_win_len"}, win_len, wl);
        chk({nm, "_fail"}, fail, f);
        chk({nm, "_cntvalue"}, cntvalue, bt);
    endtask

    // directed scenarios with literal results, then randomised scans
    initial begin
        logic [63:0] m;
        int a, l, l0;
        repeat (3) @(posedge clk_div);
        #1 rst = 1'b0;
        chk("reset_outputs", int'({load, busy, done, fail, cntvalue, best_tap, win_len}), 0);
        run_scan("all_pass", '1, 0);
        res("all_pass", 252, 64, 0);
        run_scan("mid_window", win(12, 25), 0);
        res("mid_window", 148, 14, 0);
        run_scan("two_windows", win(0, 5) | win(38, 50), 0);
        res("two_windows", 352, 13, 0);
        run_scan("equal_windows", win(0, 5) | win(50, 55), 0);
        res("equal_windows", 20, 6, 0);
        pattern = 10'h17c;
        run_scan("never_pass", '0, 0);
        res("never_pass", 0, 0, 1);
        g_tap = 160;
        g_smp = 5;
        g_bit = $urandom_range(0, 9);
        run_scan("glitch", win(12, 25), 0);
        res("glitch", 124, 8, 0);
        g_tap = -1;
        run_scan("end_window", win(50, 63), 0);
        res("end_window", 452, 14, 0);
        pmask = '1;
        l0 = n_load;
        @(posedge clk_div);
        #1 start = 1'b1;
        @(posedge clk_div);
        #1 start = 1'b0;
        for (int i = 0; i < 5 * P && n_load < l0 + 4; i++) @(posedge clk_div) #1;
        chk("abort_tap", cntvalue, 24);
        rst = 1'b1;
        @(posedge clk_div);
        #1 rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_load", load, 0);
        run_scan("restart_noisy", '1, 1);
        res("restart_noisy", 252, 64, 0);
        repeat (5) begin
            m = '0;
            repeat ($urandom_range(0, 3)) begin
                a = $urandom_range(0, 63);
                l = $urandom_range(1, 24);
                m |= win(a, a + l - 1 > 63 ? 63 : a + l - 1);
            end
            pattern = 10'($urandom);
            g_tap = $urandom_range(0, 1) == 1 ? TS * $urandom_range(0, 63) : -1;
            g_smp = $urandom_range(0, 7);
            g_bit = $urandom_range(0, 9);
            run_scan("random", m, 1);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
